// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_decoder
//  Brief    : Receive side of a multiplexed 4-digit seven-segment display.
//             Synchronizes the scanned anode/cathode lines, waits for each
//             digit dwell to settle, decodes it back to a hex nibble and dot,
//             and assembles a 4-digit frame with stall/bad-pattern flags.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2097152
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  An,
  input  logic [7:0]  Cath,
  output logic [15:0] Digits,
  output logic [3:0]  Dots,
  output logic [3:0]  Valid,
  output logic        Frame_Done,
  output logic        Bad_Pattern,
  output logic        Stalled
);

  localparam int c_stable_w = $clog2(SETTLE_CYC + 1);
  localparam int c_stall_w  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_stable_w-1:0] c_settle_max  = c_stable_w'(SETTLE_CYC);
  localparam logic [c_stable_w-1:0] c_settle_last = c_stable_w'(SETTLE_CYC - 1);
  localparam logic [c_stall_w-1:0]  c_stall_max   = c_stall_w'(TIMEOUT_CYC);
  localparam logic [c_stall_w-1:0]  c_stall_last  = c_stall_w'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_STALL   = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic [3:0] r_an_meta, r_an_sync, r_an_prev;
  logic [7:0] r_cath_meta, r_cath_sync, r_cath_prev;

  logic [c_stable_w-1:0] r_stable_cnt;
  logic                  r_captured;
  logic [c_stall_w-1:0]  r_stall_cnt;

  logic       w_sel_ok;
  logic [1:0] w_sel_idx;
  logic       w_same;
  logic       w_capture;
  logic       w_pat_ok;
  logic [3:0] w_nib;
  logic       w_good;
  logic       w_bad;
  logic       w_timeout;
  logic       w_enter_stall;
  logic       w_frame;
  logic [3:0] w_valid_next;

  // Two-flop synchronizer plus a one-cycle history copy for change detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_an_meta   <= 4'hF;
      r_an_sync   <= 4'hF;
      r_an_prev   <= 4'hF;
      r_cath_meta <= 8'hFF;
      r_cath_sync <= 8'hFF;
      r_cath_prev <= 8'hFF;
    end else begin
      r_an_meta   <= An;
      r_an_sync   <= r_an_meta;
      r_an_prev   <= r_an_sync;
      r_cath_meta <= Cath;
      r_cath_sync <= r_cath_meta;
      r_cath_prev <= r_cath_sync;
    end
  end

  // Digit select is meaningful only when exactly one anode is driven low
  always_comb begin
    w_sel_ok  = 1'b0;
    w_sel_idx = 2'd0;
    case (r_an_sync)
      4'b1110: begin w_sel_ok = 1'b1; w_sel_idx = 2'd0; end
      4'b1101: begin w_sel_ok = 1'b1; w_sel_idx = 2'd1; end
      4'b1011: begin w_sel_ok = 1'b1; w_sel_idx = 2'd2; end
      4'b0111: begin w_sel_ok = 1'b1; w_sel_idx = 2'd3; end
      default: begin w_sel_ok = 1'b0; w_sel_idx = 2'd0; end
    endcase
  end

  // Active-low abcdefg segment pattern back to its hex nibble
  always_comb begin
    w_pat_ok = 1'b1;
    w_nib    = 4'h0;
    case (r_cath_sync[7:1])
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0110000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      default:    w_pat_ok = 1'b0;
    endcase
  end

  assign w_same    = ({r_an_sync, r_cath_sync} == {r_an_prev, r_cath_prev});
  // The capture fires on the edge that would bring the count to SETTLE_CYC
  assign w_capture = w_sel_ok && w_same && !r_captured && (r_stable_cnt == c_settle_last);
  assign w_good    = w_capture && w_pat_ok;
  assign w_bad     = w_capture && !w_pat_ok;
  // A capture on the same edge always pre-empts a timeout
  assign w_timeout = !w_capture && (r_stall_cnt == c_stall_last);
  assign w_frame   = (r_state == ST_COLLECT) && (Valid == 4'hF);
  assign Stalled   = (r_state == ST_STALL);

  // Dwell stability counter and once-per-dwell capture flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stable_cnt <= '0;
      r_captured   <= 1'b0;
    end else if (!w_same || !w_sel_ok) begin
      r_stable_cnt <= '0;
      r_captured   <= 1'b0;
    end else begin
      if (r_stable_cnt != c_settle_max) r_stable_cnt <= r_stable_cnt + 1'b1;
      if (w_capture) r_captured <= 1'b1;
    end
  end

  // Cycles since the last capture, good or bad; holds once the limit is hit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (w_capture) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != c_stall_max) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_COLLECT;
    else       r_state <= w_state_next;
  end

  // FSM next-state: leave COLLECT on timeout, return on the next good capture
  always_comb begin
    w_state_next  = r_state;
    w_enter_stall = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_timeout) begin
          w_state_next  = ST_STALL;
          w_enter_stall = 1'b1;
        end
      end
      ST_STALL: begin
        if (w_good) w_state_next = ST_COLLECT;
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  // Frame completion or stall entry wipes Valid; a good capture still marks its digit
  always_comb begin
    w_valid_next = (w_frame || w_enter_stall) ? 4'h0 : Valid;
    if (w_good) w_valid_next[w_sel_idx] = 1'b1;
  end

  // Output frame registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Digits      <= '0;
      Dots        <= '0;
      Valid       <= '0;
      Frame_Done  <= 1'b0;
      Bad_Pattern <= 1'b0;
    end else begin
      if (w_good) begin
        Digits[{w_sel_idx, 2'b00} +: 4] <= w_nib;
        Dots[w_sel_idx]                 <= ~r_cath_sync[0];
      end
      if (w_bad) Bad_Pattern <= 1'b1;
      Frame_Done <= w_frame;
      Valid      <= w_valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_decoder
//  Brief    : Self-checking bench for ssd_scan_decoder (SETTLE 16, TIMEOUT 1000)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [15:0] Digits;
  logic [3:0]  Dots;
  logic [3:0]  Valid;
  logic        Frame_Done;
  logic        Bad_Pattern;
  logic        Stalled;

  ssd_scan_decoder #(.SETTLE_CYC(16), .TIMEOUT_CYC(1000)) dut (
    .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath),
    .Digits(Digits), .Dots(Dots), .Valid(Valid), .Frame_Done(Frame_Done),
    .Bad_Pattern(Bad_Pattern), .Stalled(Stalled)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  valid;
    logic        bad;
    logic        stalled;
  } exp_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cath;
    logic       frame;
    exp_t       e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   frame_cnt = 0;
  exp_t cur;
  exp_t sb[$];
  vec_t tbl[10];

  // Count Frame_Done pulses away from the active edge
  always @(negedge Clk) if (Frame_Done) frame_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, "_digits"},  Digits,      e.digits);
    chk({tag, "_dots"},    Dots,        e.dots);
    chk({tag, "_valid"},   Valid,       e.valid);
    chk({tag, "_bad"},     Bad_Pattern, e.bad);
    chk({tag, "_stalled"}, Stalled,     e.stalled);
  endtask

  // One 64-cycle dwell: check no early capture at edge 18, capture at 19, frame at 20
  task automatic run_vec(input vec_t v);
    exp_t got;
    sb.push_back(v.e);
    An   = v.an;
    Cath = v.cath;
    repeat (18) @(posedge Clk);
    #1;
    chk("pre_valid",  Valid,  cur.valid);
    chk("pre_digits", Digits, cur.digits);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      chk_state("capture", got);
      cur = got;
    end
    @(posedge Clk);
    #1;
    chk("frame_done", Frame_Done, v.frame);
    chk("post_valid", Valid, v.frame ? 4'h0 : cur.valid);
    if (v.frame) cur.valid = 4'h0;
    repeat (44) @(posedge Clk);
    #1;
  endtask

  initial begin
    // an, cath {abcdefg,Dp}, frame, {digits, dots, valid, bad, stalled}
    tbl[0] = '{4'b0111, {7'b1001111, 1'b1}, 1'b0, '{16'h1000, 4'h0, 4'b1000, 1'b0, 1'b0}};
    tbl[1] = '{4'b1011, {7'b0010010, 1'b1}, 1'b0, '{16'h1200, 4'h0, 4'b1100, 1'b0, 1'b0}};
    tbl[2] = '{4'b1101, {7'b0000110, 1'b1}, 1'b0, '{16'h1230, 4'h0, 4'b1110, 1'b0, 1'b0}};
    tbl[3] = '{4'b1110, {7'b1001100, 1'b1}, 1'b1, '{16'h1234, 4'h0, 4'b1111, 1'b0, 1'b0}};
    tbl[4] = '{4'b0111, {7'b0100100, 1'b1}, 1'b0, '{16'h5234, 4'h0, 4'b1000, 1'b0, 1'b0}};
    tbl[5] = '{4'b1011, {7'b1111111, 1'b1}, 1'b0, '{16'h5234, 4'h0, 4'b1000, 1'b1, 1'b0}};
    tbl[6] = '{4'b1101, {7'b0110001, 1'b1}, 1'b0, '{16'h52C4, 4'h0, 4'b1010, 1'b1, 1'b0}};
    tbl[7] = '{4'b1110, {7'b0110000, 1'b0}, 1'b0, '{16'h52CE, 4'h1, 4'b1011, 1'b1, 1'b0}};
    tbl[8] = '{4'b0011, {7'b0000000, 1'b1}, 1'b0, '{16'hA030, 4'h0, 4'b1000, 1'b0, 1'b0}};
    tbl[9] = '{4'b1110, {7'b0000000, 1'b0}, 1'b0, '{16'hA038, 4'h1, 4'b1001, 1'b0, 1'b0}};

    // Power-on reset
    Reset = 1'b1;
    An    = 4'hF;
    Cath  = 8'hFF;
    cur   = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk_state("por", '0);
    chk("por_frame", Frame_Done, 1'b0);
    Reset = 1'b0;

    // Full frame "1234"
    for (int i = 0; i < 4; i++) run_vec(tbl[i]);
    chk("frame_cnt_1234", frame_cnt, 1);

    // Partial frame with an undecodable digit 2
    for (int i = 4; i < 8; i++) run_vec(tbl[i]);
    chk("frame_cnt_bad", frame_cnt, 1);

    // Reset mid-frame, inputs idle so nothing is captured afterwards
    Reset = 1'b1;
    An    = 4'hF;
    Cath  = 8'hFF;
    @(posedge Clk);
    #1;
    chk_state("rst_first", '0);
    repeat (2) @(posedge Clk);
    #1;
    chk_state("rst_held", '0);
    chk("rst_frame", Frame_Done, 1'b0);
    Reset = 1'b0;
    cur   = '0;

    // Cathodes toggle every 8 cycles: never settles
    for (int d = 0; d < 4; d++) begin
      An = ~(4'b1000 >> d);
      for (int k = 0; k < 8; k++) begin
        Cath = (k % 2 == 1) ? {7'b0000000, 1'b1} : {7'b1001111, 1'b1};
        repeat (8) @(posedge Clk);
        #1;
      end
      chk("toggle_valid", Valid, 4'h0);
    end
    chk("toggle_digits", Digits, 16'h0000);
    chk("toggle_frames", frame_cnt, 1);

    // Capture one digit, then blank until the stall timer expires
    An   = 4'b1101;
    Cath = {7'b0000110, 1'b1};
    repeat (19) @(posedge Clk);
    #1;
    chk_state("stall_seed", '{16'h0030, 4'h0, 4'b0010, 1'b0, 1'b0});
    An   = 4'hF;
    Cath = 8'hFF;
    repeat (999) @(posedge Clk);
    #1;
    chk("stall_early", Stalled, 1'b0);
    chk("stall_early_valid", Valid, 4'b0010);
    @(posedge Clk);
    #1;
    chk_state("stall_enter", '{16'h0030, 4'h0, 4'b0000, 1'b0, 1'b1});

    // First good capture releases the stall
    An   = 4'b0111;
    Cath = {7'b0001000, 1'b1};
    repeat (18) @(posedge Clk);
    #1;
    chk("stall_hold", Stalled, 1'b1);
    @(posedge Clk);
    #1;
    chk_state("stall_exit", '{16'hA030, 4'h0, 4'b1000, 1'b0, 1'b0});
    repeat (45) @(posedge Clk);
    #1;
    cur = '{16'hA030, 4'h0, 4'b1000, 1'b0, 1'b0};

    // Two anodes low is ignored; dot lit on a proper dwell
    for (int i = 8; i < 10; i++) run_vec(tbl[i]);
    chk("final_frames", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
